// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared EXE op codes, divider state encoding and width
package div_iter_pkg;
   localparam int DIV_W = 32;
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_t;
   function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic s);
      return (s && v[DIV_W-1]) ? -v : v;
   endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: 32-cycle radix-2 restoring divider with signed/unsigned modes and annul
module div_iter
   import div_iter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] a,
   input  logic [DIV_W-1:0] b,
   input  logic             start,
   input  logic             signed_div,
   input  logic             annul,
   output logic [DIV_W-1:0] quotient,
   output logic [DIV_W-1:0] remainder,
   output logic             done
);
   div_state_t       state;
   logic [5:0]       cnt;
   logic [2*DIV_W:0] dvd;
   logic [DIV_W-1:0] dvs;
   logic             a_neg, b_neg;
   logic [2*DIV_W:0] shifted, step;
   logic [DIV_W:0]   trial;
   logic [DIV_W-1:0] q_fix, r_fix;
   // dvd holds {partial remainder, dividend/quotient bits}; a borrow in bit 32 means restore
   always_comb begin
      shifted = {dvd[2*DIV_W-1:0], 1'b0};
      trial   = shifted[2*DIV_W:DIV_W] - {1'b0, dvs};
      step    = trial[DIV_W] ? shifted : {trial, shifted[DIV_W-1:1], 1'b1};
      q_fix   = (a_neg ^ b_neg) ? -step[DIV_W-1:0] : step[DIV_W-1:0];
      r_fix   = a_neg ? -step[2*DIV_W-1:DIV_W] : step[2*DIV_W-1:DIV_W];
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= DIV_FREE;
         cnt       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            DIV_FREE: if (start && !annul) begin
               a_neg <= signed_div & a[DIV_W-1];
               b_neg <= signed_div & b[DIV_W-1];
               dvd   <= {{(DIV_W+1){1'b0}}, abs_val(a, signed_div)};
               dvs   <= abs_val(b, signed_div);
               cnt   <= '0;
               state <= (b == '0) ? DIV_BYZERO : DIV_ON;
            end
            DIV_BYZERO: if (annul) state <= DIV_FREE;
            else begin
               state     <= DIV_END;
               quotient  <= '0;
               remainder <= '0;
               done      <= 1'b1;
            end
            DIV_ON: if (annul) state <= DIV_FREE;
            else begin
               dvd <= step;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  state     <= DIV_END;
                  quotient  <= q_fix;
                  remainder <= r_fix;
                  done      <= 1'b1;
               end
            end
            DIV_END: state <= DIV_FREE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and random checks of div_iter against an arithmetic model
module tb_div_iter;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, signed_div = 1'b0, annul = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [31:0] quotient, remainder;
   logic        done;
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] last_q = '0, last_r = '0;
   div_iter dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .signed_div(signed_div),
      .annul(annul), .quotient(quotient), .remainder(remainder), .done(done)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
      longint sx, sy;
      if (y == 0) return 64'd0;
      if (!s) return {x / y, x % y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return {32'(sx / sy), 32'(sx % sy)};
   endfunction
   // called in the cycle right after the acceptance edge (cycle 2)
   task automatic wait_done(input string tag, input int lat, input logic [31:0] eq, input logic [31:0] er);
      int cyc = 2;
      while (!done && cyc < 60) begin
         tick();
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk({tag, " quotient"}, quotient, eq);
      chk({tag, " remainder"}, remainder, er);
      last_q = eq;
      last_r = er;
      tick();
      chk({tag, " pulse"}, 32'(done), 32'd0);
      chk({tag, " hold"}, quotient, eq);
   endtask
   task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s);
      logic [63:0] m = model(x, y, s);
      a = x;
      b = y;
      signed_div = s;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      signed_div = 1'($urandom);
      wait_done(tag, (y == 0) ? 3 : 34, m[63:32], m[31:0]);
   endtask
   initial begin
      logic [63:0] m;
      logic [31:0] x, y;
      tick();
      tick();
      chk("reset quotient", quotient, 32'd0);
      chk("reset remainder", remainder, 32'd0);
      chk("reset done", 32'(done), 32'd0);
      rst = 1'b1;
      tick();
      run("100/7", 32'h64, 32'h7, 1'b0);
      run("-7/2", 32'hFFFF_FFF9, 32'h2, 1'b1);
      run("max/1", 32'hFFFF_FFFF, 32'h1, 1'b0);
      run("minint/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run("div0", 32'h1234, 32'h0, 1'b0);
      run("-13/-4", 32'hFFFF_FFF3, 32'hFFFF_FFFC, 1'b1);
      run("13/-4", 32'd13, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         y = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : ((i % 4 == 1) ? ($urandom >> $urandom_range(0, 31)) : $urandom);
         run("random", x, y, 1'($urandom));
      end
      // annul in ON cycle 10 of 100/7, then an immediate 9/3
      a = 32'h64;
      b = 32'h7;
      signed_div = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      annul = 1'b1;
      tick();
      annul = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 0) begin
            a = 32'd9;
            b = 32'd3;
            start = 1'b1;
         end
         if (i == 1) start = 1'b0;
         if (i == 0) begin
            chk("annul no done", 32'(done), 32'd0);
            chk("annul held q", quotient, last_q);
            chk("annul held r", remainder, last_r);
         end
         if (i == 0) tick();
         if (i == 0) break;
      end
      start = 1'b0;
      wait_done("9/3 after annul", 34, 32'd3, 32'd0);
      // annul in IDLE blocks acceptance
      a = 32'd5;
      b = 32'd0;
      start = 1'b1;
      annul = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("annul idle", 32'(done), 32'd0);
      end
      annul = 1'b0;
      // held start is re-accepted after END
      a = 32'd5;
      b = 32'd0;
      tick();
      wait_done("held start 1st", 3, 32'd0, 32'd0);
      tick();
      tick();
      chk("held start reaccept", 32'(done), 32'd1);
      start = 1'b0;
      tick();
      tick();
      run("before reset", 32'd1000, 32'd33, 1'b0);
      // reset in ON cycle 20 with start held
      a = 32'h64;
      b = 32'h7;
      signed_div = 1'b0;
      start = 1'b1;
      tick();
      for (int i = 0; i < 19; i++) tick();
      rst = 1'b0;
      tick();
      chk("mid reset quotient", quotient, 32'd0);
      chk("mid reset remainder", remainder, 32'd0);
      chk("mid reset done", 32'(done), 32'd0);
      rst = 1'b1;
      tick();
      start = 1'b0;
      m = model(32'h64, 32'h7, 1'b0);
      wait_done("reaccept after reset", 34, m[63:32], m[31:0]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
